// File: rtl/detect_winner.sv
// Win/draw detector for the 4x4 Connect-4 board.
// Registers a 2-bit status: 00 in progress, 01 win, 10 draw, 11 invalid.
module detect_winner (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] game_board,
    input  logic [15:0] player_cells,
    output logic [1:0]  game_status
);

    localparam logic [1:0] IN_PROGRESS = 2'b00;
    localparam logic [1:0] WIN         = 2'b01;
    localparam logic [1:0] DRAW        = 2'b10;
    localparam logic [1:0] INVALID     = 2'b11;

    localparam logic [15:0] ROW0  = 16'h000F;
    localparam logic [15:0] ROW1  = 16'h00F0;
    localparam logic [15:0] ROW2  = 16'h0F00;
    localparam logic [15:0] ROW3  = 16'hF000;
    localparam logic [15:0] COL0  = 16'h1111;
    localparam logic [15:0] COL1  = 16'h2222;
    localparam logic [15:0] COL2  = 16'h4444;
    localparam logic [15:0] COL3  = 16'h8888;
    localparam logic [15:0] DIAG0 = 16'h8421;
    localparam logic [15:0] DIAG1 = 16'h1248;

    logic [15:0] owned;
    logic [9:0]  line_hit;
    logic        win;
    logic        invalid;
    logic        full;
    logic [1:0]  status_next;

    // Only cells that are both occupied and owned can form a line.
    assign owned = player_cells & game_board;

    // One bit per candidate line; any set bit is a win.
    always_comb begin
        line_hit[0] = (owned & ROW0)  == ROW0;
        line_hit[1] = (owned & ROW1)  == ROW1;
        line_hit[2] = (owned & ROW2)  == ROW2;
        line_hit[3] = (owned & ROW3)  == ROW3;
        line_hit[4] = (owned & COL0)  == COL0;
        line_hit[5] = (owned & COL1)  == COL1;
        line_hit[6] = (owned & COL2)  == COL2;
        line_hit[7] = (owned & COL3)  == COL3;
        line_hit[8] = (owned & DIAG0) == DIAG0;
        line_hit[9] = (owned & DIAG1) == DIAG1;
    end

    assign win     = |line_hit;
    assign invalid = |(player_cells & ~game_board);
    assign full    = (game_board == 16'hFFFF);

    // Priority: a corrupt map overrides everything, and a win on the
    // last free cell is still a win rather than a draw.
    always_comb begin
        status_next = IN_PROGRESS;
        if (invalid) begin
            status_next = INVALID;
        end else if (win) begin
            status_next = WIN;
        end else if (full) begin
            status_next = DRAW;
        end
    end

    // Status register, recomputed every cycle from the current inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_status <= IN_PROGRESS;
        end else begin
            game_status <= status_next;
        end
    end

endmodule

// File: tb/tb_detect_winner.sv
// Testbench for detect_winner.
// Expected statuses are queued at drive time and popped after the edge.
module tb_detect_winner;

    logic        clk;
    logic        reset;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic [1:0]  game_status;

    int checks;
    int errors;
    logic [1:0] exp_q[$];

    detect_winner dut (
        .clk          (clk),
        .reset        (reset),
        .game_board   (game_board),
        .player_cells (player_cells),
        .game_status  (game_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference model of the status priority.
    function automatic logic [1:0] model(input logic [15:0] b,
                                        input logic [15:0] p,
                                        input logic r);
        logic [15:0] masks[10];
        logic w;
        masks = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
                  16'h1111, 16'h2222, 16'h4444, 16'h8888,
                  16'h8421, 16'h1248};
        w = 1'b0;
        for (int i = 0; i < 10; i++)
            if (((p & b) & masks[i]) == masks[i]) w = 1'b1;
        if (r) return 2'b00;
        if ((p & ~b) != 16'h0) return 2'b11;
        if (w) return 2'b01;
        if (b == 16'hFFFF) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle, queue expected, compare after the edge.
    task automatic step(input string tag, input logic r,
                        input logic [15:0] b, input logic [15:0] p,
                        input logic [1:0] exp);
        logic [1:0] e;
        @(negedge clk);
        reset        = r;
        game_board   = b;
        player_cells = p;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_noexp"}, game_status, 2'bxx);
        end else begin
            e = exp_q.pop_front();
            chk(tag, game_status, e);
        end
    endtask

    initial begin
        logic [15:0] b;
        logic [15:0] p;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        game_board = 16'h0;
        player_cells = 16'h0;

        // Reset, including with a winning board held.
        step("rst_any",  1'b1, 16'h1234, 16'hFFFF, 2'b00);
        step("rst_win",  1'b1, 16'h000F, 16'h000F, 2'b00);
        step("rst_win2", 1'b1, 16'h000F, 16'h000F, 2'b00);

        // Column 0: not yet owned, then owned.
        step("col0_none", 1'b0, 16'h1111, 16'h0000, 2'b00);
        step("col0_win",  1'b0, 16'h1111, 16'h1111, 2'b01);

        // Line patterns.
        step("row0",  1'b0, 16'h000F, 16'h000F, 2'b01);
        step("col1",  1'b0, 16'h2222, 16'h2222, 2'b01);
        step("col2",  1'b0, 16'h4444, 16'h4444, 2'b01);
        step("diag0", 1'b0, 16'h8421, 16'h8421, 2'b01);
        step("diag1", 1'b0, 16'h1248, 16'h1248, 2'b01);
        step("row3",  1'b0, 16'hF000, 16'hF000, 2'b01);
        step("col3",  1'b0, 16'h8888, 16'h8888, 2'b01);
        step("three", 1'b0, 16'h0007, 16'h0007, 2'b00);
        step("multi", 1'b0, 16'h00FF, 16'h00FF, 2'b01);

        // Full board: draw without a line, win beats draw.
        step("draw",     1'b0, 16'hFFFF, 16'h3C3C, 2'b10);
        step("full_win", 1'b0, 16'hFFFF, 16'hF0F0, 2'b01);
        // 5A5A holds the 1248 anti-diagonal, so it is a win.
        step("full_5a",  1'b0, 16'hFFFF, 16'h5A5A, 2'b01);
        step("draw_p0",  1'b0, 16'hFFFF, 16'h0000, 2'b10);

        // Invalid ownership, including over a win.
        step("inv",     1'b0, 16'h0001, 16'h0003, 2'b11);
        step("inv_win", 1'b0, 16'h000F, 16'h001F, 2'b11);
        step("inv_top", 1'b0, 16'h7FFF, 16'h8000, 2'b11);

        // Non-sticky, and reset mid-sequence.
        step("win_a",   1'b0, 16'h1111, 16'h1111, 2'b01);
        step("clear",   1'b0, 16'h2222, 16'h0000, 2'b00);
        step("win_b",   1'b0, 16'h4444, 16'h4444, 2'b01);
        step("mid_rst", 1'b1, 16'h4444, 16'h4444, 2'b00);
        step("after",   1'b0, 16'h4444, 16'h4444, 2'b01);

        // Random boards against the model.
        for (int i = 0; i < 60; i++) begin
            b = 16'($urandom);
            p = 16'($urandom);
            if (i % 4 != 0) p = p & b;
            if (i % 5 == 0) b = 16'hFFFF;
            step("rand", (i % 17 == 16), b, p, model(b, p, (i % 17 == 16)));
        end

        chk("q_empty", {1'b0, exp_q.size() != 0}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
